// File: rtl/ref_window_fetch_pkg.sv
// Shared window-fetch definitions: FSM states, filter geometry constants, sample width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ref_window_fetch_pkg;

  localparam int SAMPLE_W = 8;
  localparam int BLK      = 4;
  localparam int TAPS     = 8;
  localparam int WIN_MAX  = BLK + TAPS - 1;  // 11
  localparam int HALO     = TAPS / 2 - 1;    // 3 samples left/above the block

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_OUT  = 2'd3
  } state_e;

  // Window side length along one axis: the block alone, or block plus filter halo.
  function automatic logic [3:0] win_dim(input logic interp);
    return interp ? 4'(WIN_MAX) : 4'(BLK);
  endfunction

endpackage

// File: rtl/ref_window_addr_gen.sv
// Window geometry for one subblock MV and clamped row address of the next row request.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module ref_window_addr_gen
  import ref_window_fetch_pkg::*;
#(
  parameter int FRAME_H = 1080
) (
  input  logic [11:0] blk_pos_x,
  input  logic [11:0] blk_pos_y,
  input  logic [14:0] mv_x_int,
  input  logic [14:0] mv_y_int,
  input  logic        interp_x,
  input  logic        interp_y,
  input  logic        start,      // a new window is being accepted this cycle
  input  logic [15:0] y0_hold,    // latched window top of the window in flight
  input  logic [3:0]  row_cur,    // row currently being delivered
  output logic [15:0] x0,
  output logic [15:0] y0,
  output logic [3:0]  win_w,
  output logic [3:0]  win_h,
  output logic [11:0] row_y       // frame row of the next request
);

  localparam logic signed [16:0] Y_MAX = 17'(FRAME_H - 1);

  logic [15:0]        base_y;
  logic [3:0]         row_off;
  logic signed [16:0] y_sum;

  // Window origin and size, then the next row's frame index clamped to the frame edges
  always_comb begin
    x0      = {4'd0, blk_pos_x} + {mv_x_int[14], mv_x_int} - (interp_x ? 16'(HALO) : 16'd0);
    y0      = {4'd0, blk_pos_y} + {mv_y_int[14], mv_y_int} - (interp_y ? 16'(HALO) : 16'd0);
    win_w   = win_dim(interp_x);
    win_h   = win_dim(interp_y);
    // A new window starts at its row 0; otherwise we address the row after the current one.
    base_y  = start ? y0 : y0_hold;
    row_off = start ? 4'd0 : row_cur + 4'd1;
    y_sum   = {base_y[15], base_y} + {13'd0, row_off};
    if (y_sum[16]) begin
      row_y = 12'd0;
    end else if (y_sum > Y_MAX) begin
      row_y = 12'(Y_MAX);
    end else begin
      row_y = y_sum[11:0];
    end
  end

endmodule

// File: rtl/ref_window_fetch.sv
// Fetches the interpolation reference window of one 4x4 subblock row by row and streams it out.
// Latency: first MEM_REQ one cycle after MV accept; each row appears one cycle after its MEM_RVALID.
// Backpressure: MEM_GNT low holds the request; ROW_READY low holds the row; MV_READY low while busy.
module ref_window_fetch #(
  parameter int SAMPLE_W = 8,
  parameter int FRAME_H  = 1080,
  parameter int WIN_MAX  = 11
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          MV_VALID,
  output logic                          MV_READY,
  input  logic [11:0]                   BLK_POS_X,
  input  logic [11:0]                   BLK_POS_Y,
  input  logic [14:0]                   MV_X_INT,
  input  logic [14:0]                   MV_Y_INT,
  input  logic [3:0]                    MV_X_FRAC,
  input  logic [3:0]                    MV_Y_FRAC,
  input  logic                          INTERP_X,
  input  logic                          INTERP_Y,
  output logic                          MEM_REQ,
  output logic [15:0]                   MEM_X,
  output logic [11:0]                   MEM_Y,
  output logic [3:0]                    MEM_LEN,
  input  logic                          MEM_GNT,
  input  logic                          MEM_RVALID,
  input  logic [WIN_MAX*SAMPLE_W-1:0]   MEM_RDATA,
  output logic                          ROW_VALID,
  input  logic                          ROW_READY,
  output logic [WIN_MAX*SAMPLE_W-1:0]   ROW_DATA,
  output logic [3:0]                    ROW_IDX,
  output logic                          ROW_LAST,
  output logic [3:0]                    OUT_FRAC_X,
  output logic [3:0]                    OUT_FRAC_Y,
  output logic                          OUT_INTERP_X,
  output logic                          OUT_INTERP_Y
);

  import ref_window_fetch_pkg::*;

  localparam int DW = WIN_MAX * SAMPLE_W;

  state_e          state_q, state_d;
  logic [3:0]      row_q, row_d;
  logic [3:0]      h_q, h_d;
  logic [15:0]     y0_q, y0_d;
  logic            mv_ready_q, mv_ready_d;
  logic            mem_req_q, mem_req_d;
  logic [15:0]     mem_x_q, mem_x_d;
  logic [11:0]     mem_y_q, mem_y_d;
  logic [3:0]      mem_len_q, mem_len_d;
  logic            row_valid_q, row_valid_d;
  logic [DW-1:0]   row_data_q, row_data_d;
  logic [3:0]      row_idx_q, row_idx_d;
  logic            row_last_q, row_last_d;
  logic [3:0]      frac_x_q, frac_x_d;
  logic [3:0]      frac_y_q, frac_y_d;
  logic            interp_x_q, interp_x_d;
  logic            interp_y_q, interp_y_d;

  logic            accept;
  logic [15:0]     ag_x0, ag_y0;
  logic [3:0]      ag_w, ag_h;
  logic [11:0]     ag_row_y;

  // mv_ready_q is only ever set while idle, so it alone qualifies the accept
  assign accept = MV_VALID & mv_ready_q;

  ref_window_addr_gen #(
    .FRAME_H (FRAME_H)
  ) u_addr_gen (
    .blk_pos_x (BLK_POS_X),
    .blk_pos_y (BLK_POS_Y),
    .mv_x_int  (MV_X_INT),
    .mv_y_int  (MV_Y_INT),
    .interp_x  (INTERP_X),
    .interp_y  (INTERP_Y),
    .start     (accept),
    .y0_hold   (y0_q),
    .row_cur   (row_q),
    .x0        (ag_x0),
    .y0        (ag_y0),
    .win_w     (ag_w),
    .win_h     (ag_h),
    .row_y     (ag_row_y)
  );

  // Next-state and next-output logic for the accept / request / wait / output loop
  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    h_d          = h_q;
    y0_d         = y0_q;
    mv_ready_d   = mv_ready_q;
    mem_req_d    = mem_req_q;
    mem_x_d      = mem_x_q;
    mem_y_d      = mem_y_q;
    mem_len_d    = mem_len_q;
    row_valid_d  = row_valid_q;
    row_data_d   = row_data_q;
    row_idx_d    = row_idx_q;
    row_last_d   = row_last_q;
    frac_x_d     = frac_x_q;
    frac_y_d     = frac_y_q;
    interp_x_d   = interp_x_q;
    interp_y_d   = interp_y_q;

    unique case (state_q)
      ST_IDLE: begin
        mv_ready_d = 1'b1;
        if (accept) begin
          state_d    = ST_REQ;
          mv_ready_d = 1'b0;
          row_d      = 4'd0;
          h_d        = ag_h;
          y0_d       = ag_y0;
          mem_req_d  = 1'b1;
          mem_x_d    = ag_x0;
          mem_y_d    = ag_row_y;
          mem_len_d  = ag_w;
          frac_x_d   = MV_X_FRAC;
          frac_y_d   = MV_Y_FRAC;
          interp_x_d = INTERP_X;
          interp_y_d = INTERP_Y;
        end
      end
      ST_REQ: begin
        if (MEM_GNT) begin
          state_d   = ST_WAIT;
          mem_req_d = 1'b0;
        end
      end
      ST_WAIT: begin
        if (MEM_RVALID) begin
          state_d     = ST_OUT;
          row_valid_d = 1'b1;
          row_data_d  = MEM_RDATA;
          row_idx_d   = row_q;
          row_last_d  = (row_q == h_q - 4'd1);
        end
      end
      ST_OUT: begin
        if (ROW_READY) begin
          row_valid_d = 1'b0;
          if (row_last_q) begin
            state_d    = ST_IDLE;
            mv_ready_d = 1'b1;
          end else begin
            state_d   = ST_REQ;
            row_d     = row_q + 4'd1;
            mem_req_d = 1'b1;
            mem_y_d   = ag_row_y;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs; reset drops any window in flight
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      row_q       <= '0;
      h_q         <= '0;
      y0_q        <= '0;
      mv_ready_q  <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_x_q     <= '0;
      mem_y_q     <= '0;
      mem_len_q   <= '0;
      row_valid_q <= 1'b0;
      row_data_q  <= '0;
      row_idx_q   <= '0;
      row_last_q  <= 1'b0;
      frac_x_q    <= '0;
      frac_y_q    <= '0;
      interp_x_q  <= 1'b0;
      interp_y_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      h_q         <= h_d;
      y0_q        <= y0_d;
      mv_ready_q  <= mv_ready_d;
      mem_req_q   <= mem_req_d;
      mem_x_q     <= mem_x_d;
      mem_y_q     <= mem_y_d;
      mem_len_q   <= mem_len_d;
      row_valid_q <= row_valid_d;
      row_data_q  <= row_data_d;
      row_idx_q   <= row_idx_d;
      row_last_q  <= row_last_d;
      frac_x_q    <= frac_x_d;
      frac_y_q    <= frac_y_d;
      interp_x_q  <= interp_x_d;
      interp_y_q  <= interp_y_d;
    end
  end

  assign MV_READY     = mv_ready_q;
  assign MEM_REQ      = mem_req_q;
  assign MEM_X        = mem_x_q;
  assign MEM_Y        = mem_y_q;
  assign MEM_LEN      = mem_len_q;
  assign ROW_VALID    = row_valid_q;
  assign ROW_DATA     = row_data_q;
  assign ROW_IDX      = row_idx_q;
  assign ROW_LAST     = row_last_q;
  assign OUT_FRAC_X   = frac_x_q;
  assign OUT_FRAC_Y   = frac_y_q;
  assign OUT_INTERP_X = interp_x_q;
  assign OUT_INTERP_Y = interp_y_q;

endmodule

// File: tb/tb_ref_window_fetch.sv
// Scoreboard bench for ref_window_fetch: MV stimulus pushes expected requests and rows,
// a memory responder and a row monitor pop and compare them independently.
// Reference model computes each window from plain integer geometry and frame clamping.
module tb_ref_window_fetch;

  localparam int SW = 8;
  localparam int WM = 11;
  localparam int DW = WM * SW;
  localparam int FH = 1080;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          MV_VALID = 1'b0;
  logic          MV_READY;
  logic [11:0]   BLK_POS_X = '0;
  logic [11:0]   BLK_POS_Y = '0;
  logic [14:0]   MV_X_INT = '0;
  logic [14:0]   MV_Y_INT = '0;
  logic [3:0]    MV_X_FRAC = '0;
  logic [3:0]    MV_Y_FRAC = '0;
  logic          INTERP_X = 1'b0;
  logic          INTERP_Y = 1'b0;
  logic          MEM_REQ;
  logic [15:0]   MEM_X;
  logic [11:0]   MEM_Y;
  logic [3:0]    MEM_LEN;
  logic          MEM_GNT = 1'b0;
  logic          MEM_RVALID = 1'b0;
  logic [DW-1:0] MEM_RDATA = '0;
  logic          ROW_VALID;
  logic          ROW_READY = 1'b0;
  logic [DW-1:0] ROW_DATA;
  logic [3:0]    ROW_IDX;
  logic          ROW_LAST;
  logic [3:0]    OUT_FRAC_X;
  logic [3:0]    OUT_FRAC_Y;
  logic          OUT_INTERP_X;
  logic          OUT_INTERP_Y;

  ref_window_fetch #(.SAMPLE_W(SW), .FRAME_H(FH), .WIN_MAX(WM)) dut (
    .CLK(CLK), .RST(RST),
    .MV_VALID(MV_VALID), .MV_READY(MV_READY),
    .BLK_POS_X(BLK_POS_X), .BLK_POS_Y(BLK_POS_Y),
    .MV_X_INT(MV_X_INT), .MV_Y_INT(MV_Y_INT),
    .MV_X_FRAC(MV_X_FRAC), .MV_Y_FRAC(MV_Y_FRAC),
    .INTERP_X(INTERP_X), .INTERP_Y(INTERP_Y),
    .MEM_REQ(MEM_REQ), .MEM_X(MEM_X), .MEM_Y(MEM_Y), .MEM_LEN(MEM_LEN),
    .MEM_GNT(MEM_GNT), .MEM_RVALID(MEM_RVALID), .MEM_RDATA(MEM_RDATA),
    .ROW_VALID(ROW_VALID), .ROW_READY(ROW_READY), .ROW_DATA(ROW_DATA),
    .ROW_IDX(ROW_IDX), .ROW_LAST(ROW_LAST),
    .OUT_FRAC_X(OUT_FRAC_X), .OUT_FRAC_Y(OUT_FRAC_Y),
    .OUT_INTERP_X(OUT_INTERP_X), .OUT_INTERP_Y(OUT_INTERP_Y)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [15:0] x;
    logic [11:0] y;
    logic [3:0]  len;
    int          row;
  } req_t;

  typedef struct {
    int          row;
    bit          last;
    logic [3:0]  fx;
    logic [3:0]  fy;
    bit          ix;
    bit          iy;
    logic [15:0] x;
    logic [11:0] y;
    int          w;
  } rowexp_t;

  req_t    req_q[$];
  rowexp_t row_q[$];
  int      checks = 0;
  int      errors = 0;

  // Memory contents: a sample pattern that depends on the addressed column and row.
  function automatic logic [DW-1:0] row_pat(input logic [15:0] x, input logic [11:0] y);
    logic [DW-1:0] d;
    d = '0;
    for (int i = 0; i < WM; i++)
      d[i*SW +: SW] = 8'(int'(x) * 5 + i * 29 + int'(y) * 11 + (int'(y) >> 8));
    return d;
  endfunction

  // Reference model: window from integer geometry, each row clamped into the frame.
  task automatic push_model(input int px, input int py, input int mvx, input int mvy,
                            input int fx, input int fy, input bit ix, input bit iy);
    int w, h, x0, y0, y;
    w  = ix ? 11 : 4;
    h  = iy ? 11 : 4;
    x0 = px + mvx - (ix ? 3 : 0);
    y0 = py + mvy - (iy ? 3 : 0);
    for (int r = 0; r < h; r++) begin
      y = y0 + r;
      if (y < 0) y = 0;
      if (y > FH - 1) y = FH - 1;
      req_q.push_back('{16'(x0), 12'(y), 4'(w), r});
      row_q.push_back('{r, (r == h - 1), 4'(fx), 4'(fy), ix, iy, 16'(x0), 12'(y), w});
    end
  endtask

  // ---------------- memory responder / request checker ----------------
  int            slow_row = -1;
  bit            saw_slow_gnt = 1'b0;
  int            gnt_hold = 0;
  int            rv_count = 0;
  logic [DW-1:0] pend_d[$];
  int            rdelay = 0;
  bit            req_stalled = 1'b0;
  logic [15:0]   sx;
  logic [11:0]   sy;
  logic [3:0]    sl;

  always @(negedge CLK) begin
    req_t e;
    MEM_RVALID = 1'b0;
    MEM_RDATA  = {$urandom, $urandom, $urandom};
    if (pend_d.size() > 0) begin
      if (rdelay > 0) rdelay--;
      else begin
        MEM_RVALID = 1'b1;
        MEM_RDATA  = pend_d.pop_front();
        rv_count++;
      end
    end
    if (RST) begin
      req_stalled = 1'b0;
      MEM_GNT = 1'b0;
    end else begin
      if (req_stalled) begin
        checks++;
        if (MEM_REQ !== 1'b1 || MEM_X !== sx || MEM_Y !== sy || MEM_LEN !== sl) begin
          errors++;
          $display("FAIL req_stable: got req=%0b x=%0d y=%0d len=%0d, held req=1 x=%0d y=%0d len=%0d",
                   MEM_REQ, MEM_X, MEM_Y, MEM_LEN, sx, sy, sl);
        end
      end
      req_stalled = 1'b0;
      if (MEM_REQ) begin
        if (gnt_hold > 0) begin
          gnt_hold--;
          MEM_GNT = 1'b0;
        end else begin
          MEM_GNT = ($urandom_range(0, 3) != 0);
        end
        if (MEM_GNT) begin
          checks++;
          if (req_q.size() == 0) begin
            errors++;
            $display("FAIL req_extra: got request x=%0d y=%0d len=%0d, required none", MEM_X, MEM_Y, MEM_LEN);
            rdelay = 0;
          end else begin
            e = req_q.pop_front();
            if (MEM_X !== e.x || MEM_Y !== e.y || MEM_LEN !== e.len) begin
              errors++;
              $display("FAIL req row %0d: got x=%0d y=%0d len=%0d, required x=%0d y=%0d len=%0d",
                       e.row, $signed(MEM_X), MEM_Y, MEM_LEN, $signed(e.x), e.y, e.len);
            end
            if (e.row == slow_row) begin
              rdelay = 6;
              saw_slow_gnt = 1'b1;
            end else begin
              rdelay = $urandom_range(0, 3);
            end
          end
          pend_d.push_back(row_pat(MEM_X, MEM_Y));
        end else begin
          req_stalled = 1'b1;
          sx = MEM_X; sy = MEM_Y; sl = MEM_LEN;
        end
      end else begin
        MEM_GNT = 1'b0;
      end
    end
  end

  // ---------------- row monitor ----------------
  int            rdy_hold = 0;
  bit            row_stalled = 1'b0;
  bit            chk_idle = 1'b0;
  logic [DW-1:0] s_data;
  logic [3:0]    s_idx, s_fx, s_fy;
  logic          s_last, s_ix, s_iy;

  always @(negedge CLK) begin
    rowexp_t       e;
    logic [DW-1:0] m;
    if (RST) begin
      row_stalled = 1'b0;
      chk_idle = 1'b0;
      ROW_READY = 1'b0;
    end else begin
      if (chk_idle) begin
        checks++;
        if (MV_READY !== 1'b1) begin
          errors++;
          $display("FAIL ready_after_last: got MV_READY=%0b, required 1", MV_READY);
        end
        chk_idle = 1'b0;
      end
      if (row_stalled) begin
        checks++;
        if (ROW_VALID !== 1'b1 || ROW_DATA !== s_data || ROW_IDX !== s_idx || ROW_LAST !== s_last ||
            OUT_FRAC_X !== s_fx || OUT_FRAC_Y !== s_fy || OUT_INTERP_X !== s_ix || OUT_INTERP_Y !== s_iy) begin
          errors++;
          $display("FAIL row_stable: got valid=%0b idx=%0d last=%0b data=%h, held idx=%0d last=%0b data=%h",
                   ROW_VALID, ROW_IDX, ROW_LAST, ROW_DATA, s_idx, s_last, s_data);
        end
      end
      row_stalled = 1'b0;
      if (ROW_VALID) begin
        if (rdy_hold > 0) begin
          rdy_hold--;
          ROW_READY = 1'b0;
        end else begin
          ROW_READY = ($urandom_range(0, 3) != 0);
        end
        if (ROW_READY) begin
          checks++;
          if (row_q.size() == 0) begin
            errors++;
            $display("FAIL row_extra: got row idx=%0d, required none", ROW_IDX);
          end else begin
            e = row_q.pop_front();
            m = '0;
            for (int i = 0; i < e.w * SW; i++) m[i] = 1'b1;
            if (ROW_IDX !== 4'(e.row) || ROW_LAST !== e.last || OUT_FRAC_X !== e.fx || OUT_FRAC_Y !== e.fy ||
                OUT_INTERP_X !== e.ix || OUT_INTERP_Y !== e.iy || (ROW_DATA & m) !== (row_pat(e.x, e.y) & m)) begin
              errors++;
              $display("FAIL row %0d: got idx=%0d last=%0b frac=%0d,%0d interp=%0b%0b data=%h, required idx=%0d last=%0b frac=%0d,%0d interp=%0b%0b data=%h",
                       e.row, ROW_IDX, ROW_LAST, OUT_FRAC_X, OUT_FRAC_Y, OUT_INTERP_X, OUT_INTERP_Y, ROW_DATA & m,
                       e.row, e.last, e.fx, e.fy, e.ix, e.iy, row_pat(e.x, e.y) & m);
            end
            if (e.last) chk_idle = 1'b1;
          end
        end else begin
          row_stalled = 1'b1;
          s_data = ROW_DATA; s_idx = ROW_IDX; s_last = ROW_LAST;
          s_fx = OUT_FRAC_X; s_fy = OUT_FRAC_Y; s_ix = OUT_INTERP_X; s_iy = OUT_INTERP_Y;
        end
      end else begin
        ROW_READY = 1'b0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send_mv(input int px, input int py, input int mvx, input int mvy,
                         input int fx, input int fy, input bit ix, input bit iy);
    int n;
    n = 0;
    @(negedge CLK);
    MV_VALID  = 1'b1;
    BLK_POS_X = 12'(px);
    BLK_POS_Y = 12'(py);
    MV_X_INT  = 15'(mvx);
    MV_Y_INT  = 15'(mvy);
    MV_X_FRAC = 4'(fx);
    MV_Y_FRAC = 4'(fy);
    INTERP_X  = ix;
    INTERP_Y  = iy;
    while (MV_READY !== 1'b1 && n < 3000) begin
      @(negedge CLK);
      n++;
    end
    checks++;
    if (MV_READY !== 1'b1) begin
      errors++;
      $display("FAIL mv_accept: got MV_READY=%0b after %0d cycles, required 1", MV_READY, n);
      MV_VALID = 1'b0;
    end else begin
      push_model(px, py, mvx, mvy, fx, fy, ix, iy);
      @(negedge CLK);
      MV_VALID  = 1'b0;
      BLK_POS_X = 12'($urandom);
      MV_Y_INT  = 15'($urandom);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((req_q.size() != 0 || row_q.size() != 0 || MV_READY !== 1'b1) && n < 5000) begin
      @(negedge CLK);
      n++;
    end
    checks++;
    if (n >= 5000) begin
      errors++;
      $display("FAIL drain: got %0d requests and %0d rows outstanding, required 0 and 0", req_q.size(), row_q.size());
      req_q.delete();
      row_q.delete();
    end
  endtask

  task automatic check_zero(input string name);
    checks++;
    if (MV_READY !== 1'b0 || MEM_REQ !== 1'b0 || MEM_X !== '0 || MEM_Y !== '0 || MEM_LEN !== '0 ||
        ROW_VALID !== 1'b0 || ROW_DATA !== '0 || ROW_IDX !== '0 || ROW_LAST !== 1'b0 ||
        OUT_FRAC_X !== '0 || OUT_FRAC_Y !== '0 || OUT_INTERP_X !== 1'b0 || OUT_INTERP_Y !== 1'b0) begin
      errors++;
      $display("FAIL %s: got ready=%0b req=%0b x=%0d y=%0d len=%0d rvalid=%0b idx=%0d last=%0b, required all 0",
               name, MV_READY, MEM_REQ, MEM_X, MEM_Y, MEM_LEN, ROW_VALID, ROW_IDX, ROW_LAST);
    end
  endtask

  initial begin
    int n, rv0, vcount;
    int px, py, mvx, mvy;

    RST = 1'b1;
    repeat (3) @(negedge CLK);
    check_zero("reset_outputs");
    RST = 1'b0;
    @(negedge CLK);
    checks++;
    if (MV_READY !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset: got %0b, required 1", MV_READY);
    end

    // Integer MV, fractional 2D, top clamp, bottom clamp
    send_mv(16, 8, 2, -1, 0, 0, 1'b0, 1'b0);   drain();
    send_mv(32, 32, 0, 0, 8, 4, 1'b1, 1'b1);   drain();
    send_mv(0, 0, 0, -5, 0, 0, 1'b0, 1'b1);    drain();
    send_mv(100, 1076, 0, 2, 0, 0, 1'b0, 1'b0); drain();

    // Grant and ready stalls on the first request/row of a window
    gnt_hold = 3;
    rdy_hold = 5;
    send_mv(200, 500, -7, 3, 5, 9, 1'b1, 1'b0);
    drain();

    // Reset while row 5 of an 11-row window is outstanding at memory
    slow_row = 5;
    saw_slow_gnt = 1'b0;
    send_mv(64, 64, 1, 1, 3, 3, 1'b1, 1'b1);
    n = 0;
    while (!saw_slow_gnt && n < 2000) begin
      @(negedge CLK);
      n++;
    end
    checks++;
    if (!saw_slow_gnt) begin
      errors++;
      $display("FAIL row5_grant: got no grant of row 5 in %0d cycles, required one", n);
    end
    @(negedge CLK);
    RST = 1'b1;
    req_q.delete();
    row_q.delete();
    rv0 = rv_count;
    @(negedge CLK);
    check_zero("reset_mid_window");
    RST = 1'b0;
    slow_row = -1;
    vcount = 0;
    repeat (12) begin
      @(negedge CLK);
      if (ROW_VALID) vcount++;
    end
    checks++;
    if (rv_count == rv0 || vcount != 0) begin
      errors++;
      $display("FAIL late_rvalid: got %0d late responses and %0d ROW_VALID cycles, required >=1 and 0",
               rv_count - rv0, vcount);
    end
    send_mv(64, 64, 1, 1, 3, 3, 1'b1, 1'b1);
    drain();

    // Randomized windows, issued back to back
    for (int k = 0; k < 30; k++) begin
      px  = int'($urandom_range(0, 1919));
      py  = int'($urandom_range(0, 1100));
      mvx = int'($urandom_range(0, 255)) - 128;
      mvy = int'($urandom_range(0, 255)) - 128;
      if ($urandom_range(0, 7) == 0) mvy = int'($urandom_range(0, 32767)) - 16384;
      if ($urandom_range(0, 7) == 0) mvx = int'($urandom_range(0, 32767)) - 16384;
      send_mv(px, py, mvx, mvy, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog: got no completion by 2 ms, required completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ref_window_fetch.md
Name: ref_window_fetch

Overview:
- Consumer of the affine MV generator output: accepts one generated subblock MV (integer part, 1/16 fraction, interpolation flags) per 4x4 subblock.
- Fetches the reference-sample window that the separable 8-tap interpolation filter needs, one row per memory request.
- Streams the rows to the interpolation datapath with the block's fraction and flag side-band.
- Sits between the MV generator control/datapath and the interpolation filter bank.

Parameters:
- SAMPLE_W, 8, bits per reference sample
- FRAME_H, 1080, frame height in samples; vertical clamp bound
- WIN_MAX, 11, maximum window width/height (BLK 4 + TAPS 8 - 1)

Ports:
- CLK  in  1  single clock, rising edge
- RST  in  1  reset, synchronous and active-high
- MV_VALID  in  1  MV input valid
- MV_READY  out  1  block can accept an MV
- BLK_POS_X  in  12  subblock top-left x in frame, unsigned
- BLK_POS_Y  in  12  subblock top-left y in frame, unsigned
- MV_X_INT  in  15  signed integer MV x
- MV_Y_INT  in  15  signed integer MV y
- MV_X_FRAC  in  4  1/16 fraction x
- MV_Y_FRAC  in  4  1/16 fraction y
- INTERP_X  in  1  horizontal interpolation needed
- INTERP_Y  in  1  vertical interpolation needed
- MEM_REQ  out  1  row read request
- MEM_X  out  16  signed window start column; horizontal edge padding is done by the memory wrapper
- MEM_Y  out  12  row index, clamped to [0, FRAME_H-1]
- MEM_LEN  out  4  samples requested: 4 or 11
- MEM_GNT  in  1  request accepted
- MEM_RVALID  in  1  row data valid; in order, one per granted request
- MEM_RDATA  in  WIN_MAX*SAMPLE_W  row samples, sample 0 in LSBs
- ROW_VALID  out  1  output row valid
- ROW_READY  in  1  filter accepts row
- ROW_DATA  out  WIN_MAX*SAMPLE_W  registered row
- ROW_IDX  out  4  row number within window
- ROW_LAST  out  1  final row of window
- OUT_FRAC_X  out  4  latched fraction x
- OUT_FRAC_Y  out  4  latched fraction y
- OUT_INTERP_X  out  1  latched flag x
- OUT_INTERP_Y  out  1  latched flag y

Behaviour:
- Reset values: all outputs, state and internal registers are 0. State is IDLE. MV_READY is 1 on the first cycle after reset release.
- FSM has four states: IDLE, REQ, WAIT, OUT.
- IDLE:
  - MV_READY=1.
  - On MV_VALID, latch all inputs and compute the window, then go to REQ.
  - MEM_RVALID is ignored in IDLE.
- Window geometry:
  - Width W = INTERP_X ? 11 : 4. Height H = INTERP_Y ? 11 : 4.
  - X0 = BLK_POS_X + MV_X_INT - (INTERP_X ? 3 : 0), 16-bit signed, no saturation.
  - Y0 = BLK_POS_Y + MV_Y_INT - (INTERP_Y ? 3 : 0), 16-bit signed.
- REQ:
  - MEM_REQ=1, MEM_X=X0, MEM_LEN=W.
  - MEM_Y = clamp(Y0 + row, 0, FRAME_H-1). Rows above or below the frame repeat the edge row.
  - Outputs hold stable until MEM_GNT. On MEM_GNT go to WAIT.
  - First MEM_REQ is asserted in the cycle after MV acceptance.
- WAIT:
  - On MEM_RVALID, register MEM_RDATA into ROW_DATA, then go to OUT.
  - Lanes at index W and above are don't-care.
- OUT:
  - ROW_VALID=1. ROW_IDX=row. ROW_LAST=(row==H-1).
  - Side-band outputs are stable for the whole window.
  - On ROW_READY: if ROW_LAST go to IDLE, else row+1 and go to REQ.
  - With ROW_READY=0, ROW_DATA and all flags hold.
- Only one memory request is outstanding at a time. A new MV is accepted at the earliest in the cycle after the last-row handshake.
- Row counter is 4 bits and resets to 0 at each MV accept. It never exceeds 10.
- RST asserted mid-window: state returns to IDLE next cycle and the window is dropped. MEM_RVALID that arrives after reset is ignored.
- MV_VALID while not in IDLE: not accepted, because MV_READY=0. The upstream unit holds its data.

Decomposition:
- Shared package holds:
  - state encoding (IDLE/REQ/WAIT/OUT)
  - constants BLK=4, TAPS=8, WIN_MAX=11, HALO=3
  - sample width
- One natural sub-module: ref_window_addr_gen. It is combinational and produces X0, Y0, W, H and the clamped row Y.
- FSM and registers stay in the top module.

Test Plan:
- Integer MV: BLK_POS=(16,8), MV_INT=(2,-1), INTERP=0,0 -> 4 requests with MEM_X=18, MEM_Y=7,8,9,10, MEM_LEN=4; ROW_LAST on row 3; MV_READY returns 1 after the last handshake.
- Fractional 2D: pos (32,32), MV_INT=(0,0), FRAC=(8,4), INTERP=1,1 -> 11 requests, MEM_X=29, MEM_Y=29..39, MEM_LEN=11; OUT_FRAC=(8,4) held on all rows.
- Top-edge clamp: pos (0,0), MV_Y_INT=-5, INTERP_Y=1 -> Y0=-8; MEM_Y=0 for rows 0..8, then 1, 2.
- Bottom-edge clamp: pos_y=1076, MV_Y_INT=+2, INTERP_Y=0 -> MEM_Y=1078, 1079, 1079, 1079.
- Backpressure and stalls: hold MEM_GNT low 3 cycles and ROW_READY low 5 cycles -> MEM_REQ, MEM_X and MEM_Y stay stable; ROW_DATA is unchanged; no extra request is issued.
- Reset mid-window: assert RST at row 5 of 11 -> next cycle IDLE, all outputs 0; a late MEM_RVALID produces no ROW_VALID; the next MV fetches correctly from row 0.
